pio_input_conditioner: RTL and testbench

//  Input stage directly upstream of the PIO block: synchronises raw pins, optionally debounces them,
//  and drives the PIO pin-input bus (oPIO -> PIO iPIO). Also detects rising/falling edges

---
 rtl/pio_input_conditioner_if.sv | 25 ++
 rtl/pio_input_conditioner.sv | 244 ++++++++++++++++++++++++
 tb/tb_pio_input_conditioner.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pio_input_conditioner_if.sv
// Register-slave bus of the PIO input conditioner: word address, read/write
// strobes, write data and registered read data.
interface pio_input_conditioner_if;
    logic [2:0]  iADDRESS;
    logic        iWRITE;
    logic        iREAD;
    logic [31:0] iWRITE_DATA;
    logic [31:0] oREAD_DATA;

    modport master (
        output iADDRESS,
        output iWRITE,
        output iREAD,
        output iWRITE_DATA,
        input  oREAD_DATA
    );

    modport slave (
        input  iADDRESS,
        input  iWRITE,
        input  iREAD,
        input  iWRITE_DATA,
        output oREAD_DATA
    );
endinterface

// File: rtl/pio_input_conditioner.sv
// PIO input conditioner: 2-FF synchroniser, optional prescaled 3-sample
// debounce, edge detection into a sticky PENDING register and a level IRQ.
// Optional feature macro: PIO_INPUT_CONDITIONER_TIMESTAMP_EN adds a free-running
// cycle counter and a TSTAMP capture of the first pending edge (address 6).
module pio_input_conditioner #(
    parameter int pBITS     = 32,
    parameter int pDIV_BITS = 16
) (
    input  logic                  iCLOCK,
    input  logic                  iRESET,
    pio_input_conditioner_if.slave bus,
    input  logic [pBITS-1:0]      iPIN,
    output logic [pBITS-1:0]      oPIO,
    output logic                  oIRQ
);

    localparam logic [2:0] ADDR_VALUE   = 3'd0;
    localparam logic [2:0] ADDR_RISE_EN = 3'd1;
    localparam logic [2:0] ADDR_FALL_EN = 3'd2;
    localparam logic [2:0] ADDR_PENDING = 3'd3;
    localparam logic [2:0] ADDR_MASK    = 3'd4;
    localparam logic [2:0] ADDR_DIV     = 3'd5;
    localparam logic [2:0] ADDR_TSTAMP  = 3'd6;

    localparam logic [pDIV_BITS-1:0] PRESC_ZERO = {pDIV_BITS{1'b0}};
    localparam logic [pDIV_BITS-1:0] PRESC_ONE  = pDIV_BITS'(1'b1);
    localparam logic [pBITS-1:0]     BITS_ZERO  = {pBITS{1'b0}};

    // Zero-extend a pin-wide value onto the 32-bit read bus.
    function automatic logic [31:0] zext_bits(input logic [pBITS-1:0] v);
        logic [31:0] r;
        r = 32'd0;
        r[pBITS-1:0] = v;
        return r;
    endfunction

    // Zero-extend the divider onto the 32-bit read bus.
    function automatic logic [31:0] zext_div(input logic [pDIV_BITS-1:0] v);
        logic [31:0] r;
        r = 32'd0;
        r[pDIV_BITS-1:0] = v;
        return r;
    endfunction

    logic [pBITS-1:0]     sync1_r;
    logic [pBITS-1:0]     sync2_r;
    logic [pBITS-1:0]     hist0_r;
    logic [pBITS-1:0]     hist1_r;
    logic [pBITS-1:0]     pio_r;
    logic [pBITS-1:0]     prev_r;
    logic [pBITS-1:0]     rise_en_r;
    logic [pBITS-1:0]     fall_en_r;
    logic [pBITS-1:0]     pending_r;
    logic [pBITS-1:0]     mask_r;
    logic [pDIV_BITS-1:0] div_r;
    logic [pDIV_BITS-1:0] presc_r;
    logic                 irq_r;
    logic [31:0]          rdata_r;

    logic                 wr_rise_s;
    logic                 wr_fall_s;
    logic                 wr_pend_s;
    logic                 wr_mask_s;
    logic                 wr_div_s;
    logic [pBITS-1:0]     w1c_s;
    logic                 bypass_s;
    logic                 tick_s;
    logic [pBITS-1:0]     agree_s;
    logic [pBITS-1:0]     pio_next_s;
    logic [pBITS-1:0]     rise_s;
    logic [pBITS-1:0]     fall_s;
    logic [pBITS-1:0]     pending_next_s;
    logic [31:0]          tstamp_s;
    logic [31:0]          rdata_s;

    // Decode the write strobe into one enable per writable register.
    always_comb begin
        wr_rise_s = 1'b0;
        wr_fall_s = 1'b0;
        wr_pend_s = 1'b0;
        wr_mask_s = 1'b0;
        wr_div_s  = 1'b0;
        if (bus.iWRITE) begin
            case (bus.iADDRESS)
                ADDR_RISE_EN: wr_rise_s = 1'b1;
                ADDR_FALL_EN: wr_fall_s = 1'b1;
                ADDR_PENDING: wr_pend_s = 1'b1;
                ADDR_MASK:    wr_mask_s = 1'b1;
                ADDR_DIV:     wr_div_s  = 1'b1;
                default:      wr_rise_s = 1'b0;
            endcase
        end else begin
            wr_rise_s = 1'b0;
        end
    end

    assign w1c_s    = wr_pend_s ? bus.iWRITE_DATA[pBITS-1:0] : BITS_ZERO;
    assign bypass_s = (div_r == PRESC_ZERO);
    assign tick_s   = !bypass_s && (presc_r == div_r);

    // A bit is accepted only when the two stored tick samples and the new one agree.
    assign agree_s  = ~(hist1_r ^ hist0_r) & ~(hist0_r ^ sync2_r);

    // Next conditioned pin state: straight through in bypass, debounced otherwise.
    always_comb begin
        pio_next_s = pio_r;
        if (bypass_s) begin
            pio_next_s = sync2_r;
        end else if (tick_s) begin
            pio_next_s = (agree_s & sync2_r) | (~agree_s & pio_r);
        end else begin
            pio_next_s = pio_r;
        end
    end

    assign rise_s         = pio_r & ~prev_r & rise_en_r;
    assign fall_s         = ~pio_r & prev_r & fall_en_r;
    // Set beats clear: a new edge in the same cycle as its W1C keeps the bit set.
    assign pending_next_s = (pending_r & ~w1c_s) | rise_s | fall_s;

`ifdef PIO_INPUT_CONDITIONER_TIMESTAMP_EN
    logic [31:0] cycle_cnt_r;
    logic [31:0] tstamp_r;

    // Free-running cycle counter and capture on the first pending edge.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            cycle_cnt_r <= 32'd0;
            tstamp_r    <= 32'd0;
        end else begin
            cycle_cnt_r <= cycle_cnt_r + 32'd1;
            if ((pending_r == BITS_ZERO) && (pending_next_s != BITS_ZERO)) begin
                tstamp_r <= cycle_cnt_r;
            end
        end
    end

    assign tstamp_s = tstamp_r;
`else
    assign tstamp_s = 32'd0;
`endif

    // Read-data multiplexer; unused upper bits and the reserved word read 0.
    always_comb begin
        rdata_s = 32'd0;
        case (bus.iADDRESS)
            ADDR_VALUE:   rdata_s = zext_bits(pio_r);
            ADDR_RISE_EN: rdata_s = zext_bits(rise_en_r);
            ADDR_FALL_EN: rdata_s = zext_bits(fall_en_r);
            ADDR_PENDING: rdata_s = zext_bits(pending_r);
            ADDR_MASK:    rdata_s = zext_bits(mask_r);
            ADDR_DIV:     rdata_s = zext_div(div_r);
            ADDR_TSTAMP:  rdata_s = tstamp_s;
            default:      rdata_s = 32'd0;
        endcase
    end

    // Two-flop synchroniser on the raw pins.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            sync1_r <= BITS_ZERO;
            sync2_r <= BITS_ZERO;
        end else begin
            sync1_r <= iPIN;
            sync2_r <= sync1_r;
        end
    end

    // Debounce prescaler: counts 0..DIV and restarts on any DIV write.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            presc_r <= PRESC_ZERO;
        end else if (wr_div_s || bypass_s || tick_s) begin
            presc_r <= PRESC_ZERO;
        end else begin
            presc_r <= presc_r + PRESC_ONE;
        end
    end

    // Tick-sample history, conditioned pin state and previous-state copy for edges.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            hist0_r <= BITS_ZERO;
            hist1_r <= BITS_ZERO;
            pio_r   <= BITS_ZERO;
            prev_r  <= BITS_ZERO;
        end else begin
            if (tick_s) begin
                hist1_r <= hist0_r;
                hist0_r <= sync2_r;
            end
            pio_r  <= pio_next_s;
            prev_r <= pio_r;
        end
    end

    // Software-visible configuration registers.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            rise_en_r <= BITS_ZERO;
            fall_en_r <= BITS_ZERO;
            mask_r    <= BITS_ZERO;
            div_r     <= PRESC_ZERO;
        end else begin
            if (wr_rise_s) begin
                rise_en_r <= bus.iWRITE_DATA[pBITS-1:0];
            end
            if (wr_fall_s) begin
                fall_en_r <= bus.iWRITE_DATA[pBITS-1:0];
            end
            if (wr_mask_s) begin
                mask_r <= bus.iWRITE_DATA[pBITS-1:0];
            end
            if (wr_div_s) begin
                div_r <= bus.iWRITE_DATA[pDIV_BITS-1:0];
            end
        end
    end

    // Sticky pending flags and the level interrupt derived from them.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            pending_r <= BITS_ZERO;
            irq_r     <= 1'b0;
        end else begin
            pending_r <= pending_next_s;
            irq_r     <= |(pending_r & mask_r);
        end
    end

    // Registered read data, captured only on a read strobe.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            rdata_r <= 32'd0;
        end else if (bus.iREAD) begin
            rdata_r <= rdata_s;
        end
    end

    assign oPIO           = pio_r;
    assign oIRQ           = irq_r;
    assign bus.oREAD_DATA = rdata_r;

endmodule

// File: tb/tb_pio_input_conditioner.sv
// Self-checking bench for pio_input_conditioner: register reads are checked
// through an expected-value queue, pin/IRQ outputs are checked directly.
module tb_pio_input_conditioner;

    logic        iCLOCK;
    logic        iRESET;
    logic [31:0] iPIN;
    logic [31:0] oPIO;
    logic        oIRQ;

    pio_input_conditioner_if bus ();

    pio_input_conditioner #(.pBITS(32), .pDIV_BITS(16)) dut (
        .iCLOCK (iCLOCK),
        .iRESET (iRESET),
        .bus    (bus.slave),
        .iPIN   (iPIN),
        .oPIO   (oPIO),
        .oIRQ   (oIRQ)
    );

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t        exp_q[$];
    int          checks_cnt;
    int          failures_cnt;
    int          stamp;
    logic [31:0] exp_ts;
    logic        rd_seen;

    initial begin
        iCLOCK = 1'b0;
        forever #5 iCLOCK = ~iCLOCK;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            failures_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge iCLOCK);
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        bus.iADDRESS    = addr;
        bus.iWRITE_DATA = data;
        bus.iWRITE      = 1'b1;
        @(negedge iCLOCK);
        bus.iWRITE      = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] addr, input logic [31:0] exp, input string tag);
        exp_t e;
        e.tag   = tag;
        e.value = exp;
        exp_q.push_back(e);
        bus.iADDRESS = addr;
        bus.iREAD    = 1'b1;
        @(negedge iCLOCK);
        bus.iREAD    = 1'b0;
    endtask

    // Read monitor plus a reference cycle counter mirroring reset behaviour.
    initial begin
        exp_t e;
        stamp = 0;
        forever begin
            @(posedge iCLOCK);
            rd_seen = bus.iREAD;
            if (iRESET) stamp = 0;
            else        stamp = stamp + 1;
            #1;
            if (rd_seen) begin
                if (exp_q.size() == 0) begin
                    check_value("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_value(e.tag, bus.oREAD_DATA, e.value);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks_cnt      = 0;
        failures_cnt    = 0;
        exp_ts          = 32'd0;
        iRESET          = 1'b1;
        iPIN            = 32'd0;
        bus.iADDRESS    = 3'd0;
        bus.iWRITE      = 1'b0;
        bus.iREAD       = 1'b0;
        bus.iWRITE_DATA = 32'd0;
        tick(3);
        iRESET = 1'b0;
        tick(1);

        // Reset state
        check_value("rst_pio", oPIO, 32'd0);
        check_value("rst_irq", {31'd0, oIRQ}, 32'd0);
        for (int a = 0; a < 8; a++) bus_read(3'(a), 32'd0, $sformatf("rst_reg%0d", a));

        // Bypass path latency: pin -> oPIO edge 2, PENDING edge 3, IRQ edge 4
        bus_write(3'd1, 32'h1);
        bus_write(3'd4, 32'h1);
        iPIN = 32'h1;
        tick(2);
        check_value("byp_pio_e1", oPIO, 32'h0);
        tick(1);
        check_value("byp_pio_e2", oPIO, 32'h1);
        check_value("byp_irq_e2", {31'd0, oIRQ}, 32'd0);
        tick(1);
        check_value("byp_irq_e3", {31'd0, oIRQ}, 32'd0);
        tick(1);
        check_value("byp_irq_e4", {31'd0, oIRQ}, 32'd1);
        bus_read(3'd3, 32'h1, "byp_pending");
        bus_read(3'd0, 32'h1, "byp_value");
        bus_write(3'd3, 32'h1);
        tick(1);
        check_value("w1c_irq_clr", {31'd0, oIRQ}, 32'd0);
        bus_read(3'd3, 32'h0, "w1c_pending");

        // Debounce with DIV=3: held level accepted in edges 10..13
        bus_write(3'd5, 32'h3);
        bus_read(3'd5, 32'h3, "div_rb");
        tick(20);
        iPIN = 32'h21;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            if (i <= 9) check_value($sformatf("deb_hold_e%0d", i), oPIO & 32'h20, 32'h0);
        end
        check_value("deb_rise_e13", oPIO & 32'h20, 32'h20);
        check_value("deb_bit0", oPIO & 32'h1, 32'h1);

        // 5-cycle pulse on pin 6 must be rejected
        iPIN = 32'h61;
        tick(5);
        iPIN = 32'h21;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            check_value($sformatf("deb_pulse_c%0d", i), oPIO & 32'h40, 32'h0);
        end

        // Back to bypass; build PENDING=0x3 then W1C bit 0
        bus_write(3'd5, 32'h0);
        bus_write(3'd1, 32'h3);
        bus_write(3'd2, 32'h3);
        iPIN = 32'h22;
        tick(6);
        bus_read(3'd3, 32'h3, "pend_both");
        bus_write(3'd3, 32'h1);
        bus_read(3'd3, 32'h2, "pend_w1c_b0");
        // W1C of bit 1 lands on the same edge a new fall sets it
        iPIN = 32'h20;
        tick(3);
        bus_write(3'd3, 32'h2);
        bus_read(3'd3, 32'h2, "pend_set_wins");
        bus_write(3'd3, 32'hFFFF_FFFF);
        bus_read(3'd3, 32'h0, "pend_clr_all");

        // Falling-edge detect with mask off, then mask on; timestamp capture
        bus_write(3'd1, 32'h0);
        bus_write(3'd2, 32'h0);
        bus_write(3'd4, 32'h0);
        iPIN = 32'hA0;
        tick(6);
        bus_write(3'd2, 32'h80);
        bus_write(3'd3, 32'hFFFF_FFFF);
        tick(2);
        iPIN = 32'h20;
        tick(4);
        exp_ts = 32'(stamp - 1);
        tick(2);
        bus_read(3'd3, 32'h80, "fall_pending");
        check_value("fall_irq_masked", {31'd0, oIRQ}, 32'd0);
        bus_write(3'd4, 32'h80);
        check_value("mask_irq_same", {31'd0, oIRQ}, 32'd0);
        tick(1);
        check_value("mask_irq_next", {31'd0, oIRQ}, 32'd1);
        bus_write(3'd2, 32'h0);
        bus_read(3'd3, 32'h80, "fall_en_clr_keeps");
`ifdef PIO_INPUT_CONDITIONER_TIMESTAMP_EN
        bus_read(3'd6, exp_ts, "tstamp_first");
`else
        bus_read(3'd6, 32'h0, "tstamp_absent");
`endif
        bus_write(3'd1, 32'h1);
        iPIN = 32'h21;
        tick(6);
        bus_read(3'd3, 32'h81, "pend_second");
`ifdef PIO_INPUT_CONDITIONER_TIMESTAMP_EN
        bus_read(3'd6, exp_ts, "tstamp_hold");
`else
        bus_read(3'd6, 32'h0, "tstamp_absent2");
`endif
        bus_write(3'd7, 32'hDEAD_BEEF);
        bus_read(3'd7, 32'h0, "reserved");

        // Reset in the middle of a long debounce count
        bus_write(3'd5, 32'hFFFF);
        tick(10);
        iRESET = 1'b1;
        tick(1);
        iRESET = 1'b0;
        tick(1);
        check_value("mrst_pio", oPIO, 32'd0);
        check_value("mrst_irq", {31'd0, oIRQ}, 32'd0);
        iPIN = 32'h0;
        tick(5);
        for (int a = 0; a < 8; a++) bus_read(3'(a), 32'd0, $sformatf("mrst_reg%0d", a));
        tick(2);
        check_value("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule
